// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared micro-state numbers and ALU opcodes for the RISC control path
package cpu_pkg;

    localparam int ST_W = 6;

    typedef enum logic [ST_W-1:0] {
        S_RESET   = 6'd0,
        S_FETCH1  = 6'd1,
        S_FETCH2  = 6'd2,
        S_FETCH3  = 6'd3,
        S_DECODE  = 6'd4,
        S_ADD_RR  = 6'd10,
        S_ADD_SH  = 6'd11,
        S_ADD_IMM = 6'd12,
        S_CMP     = 6'd13,
        S_MOV     = 6'd14,
        S_LDR1    = 6'd20,
        S_LDR2    = 6'd21,
        S_LDR3    = 6'd22,
        S_STR1    = 6'd25,
        S_STR2    = 6'd26,
        S_STR3    = 6'd27,
        S_BEQ     = 6'd30,
        S_BTAKEN  = 6'd31
    } state_t;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADD   = 4'b0100;
    localparam logic [3:0] ALU_SUB   = 4'b1010;
    localparam logic [3:0] ALU_PASSB = 4'b1101;

    // Execute entry points the encoder is allowed to hand to DECODE.
    function automatic logic is_dispatch_target(input logic [ST_W-1:0] s);
        case (s)
            S_ADD_RR, S_ADD_SH, S_ADD_IMM, S_CMP, S_MOV,
            S_LDR1, S_STR1, S_BEQ: is_dispatch_target = 1'b1;
            default:               is_dispatch_target = 1'b0;
        endcase
    endfunction

    function automatic logic is_wait_state(input state_t s);
        is_wait_state = (s == S_FETCH3) || (s == S_LDR2) || (s == S_STR3);
    endfunction

endpackage

// File: rtl/moc_watchdog.sv
// rtl/moc_watchdog.sv - counts memory wait cycles and flags an abandoned access
module moc_watchdog #(
    parameter int MOC_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic in_wait,
    input  logic moc,
    output logic expired
);

    localparam int CNT_W = (MOC_TIMEOUT > 1) ? $clog2(MOC_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(MOC_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Outside a wait state the count sits at zero, so every wait starts fresh;
    // a moc on the terminal cycle suppresses the expiry.
    always_comb begin
        expired = in_wait && !moc && (cnt_q == TERM);
        cnt_d   = '0;
        if (in_wait && !moc && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer driving datapath strobes
module control_sequencer #(
    parameter int MOC_TIMEOUT = 16,
    parameter int ST_W        = cpu_pkg::ST_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ST_W-1:0] enc_state,
    input  logic            moc,
    input  logic            cond_true,
    output logic [ST_W-1:0] state,
    output logic            mar_ld,
    output logic            mdr_ld,
    output logic            ir_ld,
    output logic            pc_ld,
    output logic            rf_ld,
    output logic            flags_ld,
    output logic            pc_inc,
    output logic [3:0]      alu_op,
    output logic            mem_en,
    output logic            mem_rw,
    output logic            mem_err
);

    import cpu_pkg::*;

    state_t state_q;
    state_t state_d;
    logic   in_wait;
    logic   expired;

    assign in_wait = is_wait_state(state_q);
    assign state   = state_q;
    assign mem_err = expired;

    moc_watchdog #(
        .MOC_TIMEOUT(MOC_TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (reset),
        .in_wait (in_wait),
        .moc     (moc),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Strobes decode from the state register; only the MDR/IR captures are
    // qualified by moc so they land on the cycle the read data is valid.
    always_comb begin
        state_d  = S_RESET;
        mar_ld   = 1'b0;
        mdr_ld   = 1'b0;
        ir_ld    = 1'b0;
        pc_ld    = 1'b0;
        rf_ld    = 1'b0;
        flags_ld = 1'b0;
        pc_inc   = 1'b0;
        alu_op   = ALU_NOP;
        mem_en   = 1'b0;
        mem_rw   = 1'b0;

        case (state_q)
            S_RESET: begin
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                mar_ld  = 1'b1;
                state_d = S_FETCH2;
            end
            S_FETCH2: begin
                pc_ld   = 1'b1;
                pc_inc  = 1'b1;
                mem_en  = 1'b1;
                mem_rw  = 1'b1;
                state_d = S_FETCH3;
            end
            S_FETCH3: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                if (moc) begin
                    mdr_ld  = 1'b1;
                    ir_ld   = 1'b1;
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_FETCH1;
                end else begin
                    state_d = S_FETCH3;
                end
            end
            S_DECODE: begin
                if (is_dispatch_target(enc_state)) begin
                    state_d = state_t'(enc_state);
                end else begin
                    state_d = S_FETCH1;
                end
            end
            S_ADD_RR, S_ADD_SH, S_ADD_IMM: begin
                rf_ld   = 1'b1;
                alu_op  = ALU_ADD;
                state_d = S_FETCH1;
            end
            S_CMP: begin
                flags_ld = 1'b1;
                alu_op   = ALU_SUB;
                state_d  = S_FETCH1;
            end
            S_MOV: begin
                rf_ld   = 1'b1;
                alu_op  = ALU_PASSB;
                state_d = S_FETCH1;
            end
            S_LDR1: begin
                mar_ld  = 1'b1;
                alu_op  = ALU_ADD;
                state_d = S_LDR2;
            end
            S_LDR2: begin
                mem_en = 1'b1;
                mem_rw = 1'b1;
                if (moc) begin
                    mdr_ld  = 1'b1;
                    state_d = S_LDR3;
                end else if (expired) begin
                    state_d = S_FETCH1;
                end else begin
                    state_d = S_LDR2;
                end
            end
            S_LDR3: begin
                rf_ld   = 1'b1;
                alu_op  = ALU_PASSB;
                state_d = S_FETCH1;
            end
            S_STR1: begin
                mar_ld  = 1'b1;
                alu_op  = ALU_ADD;
                state_d = S_STR2;
            end
            S_STR2: begin
                mdr_ld  = 1'b1;
                state_d = S_STR3;
            end
            S_STR3: begin
                mem_en = 1'b1;
                mem_rw = 1'b0;
                if (moc || expired) begin
                    state_d = S_FETCH1;
                end else begin
                    state_d = S_STR3;
                end
            end
            S_BEQ: begin
                state_d = cond_true ? S_BTAKEN : S_FETCH1;
            end
            S_BTAKEN: begin
                pc_ld   = 1'b1;
                pc_inc  = 1'b0;
                alu_op  = ALU_ADD;
                state_d = S_FETCH1;
            end
            default: begin
                state_d = S_RESET;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed-vector bench for control_sequencer
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  enc_state;
    logic        moc;
    logic        cond_true;
    logic [5:0]  state;
    logic        mar_ld, mdr_ld, ir_ld, pc_ld, rf_ld, flags_ld, pc_inc;
    logic [3:0]  alu_op;
    logic        mem_en, mem_rw, mem_err;
    logic [13:0] obs;

    int total = 0;
    int bad   = 0;

    // obs bits: mar mdr ir pc_ld rf flags pc_inc mem_en mem_rw mem_err alu_op[3:0]
    assign obs = {mar_ld, mdr_ld, ir_ld, pc_ld, rf_ld, flags_ld, pc_inc,
                  mem_en, mem_rw, mem_err, alu_op};

    typedef struct packed {
        logic        m;
        logic        c;
        logic [5:0]  e;
        logic [5:0]  s;
        logic [13:0] o;
    } row_t;

    control_sequencer #(
        .MOC_TIMEOUT(16),
        .ST_W       (6)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enc_state (enc_state),
        .moc       (moc),
        .cond_true (cond_true),
        .state     (state),
        .mar_ld    (mar_ld),
        .mdr_ld    (mdr_ld),
        .ir_ld     (ir_ld),
        .pc_ld     (pc_ld),
        .rf_ld     (rf_ld),
        .flags_ld  (flags_ld),
        .pc_inc    (pc_inc),
        .alu_op    (alu_op),
        .mem_en    (mem_en),
        .mem_rw    (mem_rw),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    function automatic row_t r(input logic m, input logic c, input logic [5:0] e,
                               input logic [5:0] s, input logic [13:0] o);
        r = {m, c, e, s, o};
    endfunction

    task automatic test_reset;
        reset = 1'b1; moc = 1'b0; cond_true = 1'b0; enc_state = 6'd0;
        #1;
        total++;
        if (state !== 6'd0 || obs !== 14'h0000) begin
            bad++;
            $display("FAIL reset_init: state=%0d out=%h, expected state=0 out=0000", state, obs);
        end
        @(negedge clk); #1;
        total++;
        if (state !== 6'd0 || obs !== 14'h0000) begin
            bad++;
            $display("FAIL reset_held: state=%0d out=%h, expected state=0 out=0000", state, obs);
        end
        reset = 1'b0;
    endtask

    task automatic test_add;
        row_t rows[$];
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd10, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd10, 14'h0204));
        foreach (rows[i]) begin
            @(negedge clk);
            moc = rows[i].m; cond_true = rows[i].c; enc_state = rows[i].e;
            #1;
            total++;
            if (state !== rows[i].s || obs !== rows[i].o) begin
                bad++;
                $display("FAIL add[%0d]: state=%0d out=%h, expected state=%0d out=%h",
                         i, state, obs, rows[i].s, rows[i].o);
            end
        end
    endtask

    task automatic test_ldr_wait;
        row_t rows[$];
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd20, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd20, 14'h2004));
        rows.push_back(r(0, 0, 6'd0,  6'd21, 14'h0060));
        rows.push_back(r(0, 0, 6'd0,  6'd21, 14'h0060));
        rows.push_back(r(0, 0, 6'd0,  6'd21, 14'h0060));
        rows.push_back(r(1, 0, 6'd0,  6'd21, 14'h1060));
        rows.push_back(r(0, 0, 6'd0,  6'd22, 14'h020D));
        foreach (rows[i]) begin
            @(negedge clk);
            moc = rows[i].m; cond_true = rows[i].c; enc_state = rows[i].e;
            #1;
            total++;
            if (state !== rows[i].s || obs !== rows[i].o) begin
                bad++;
                $display("FAIL ldr[%0d]: state=%0d out=%h, expected state=%0d out=%h",
                         i, state, obs, rows[i].s, rows[i].o);
            end
        end
    endtask

    task automatic test_beq;
        row_t rows[$];
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd30, 6'd4,  14'h0000));
        rows.push_back(r(0, 1, 6'd0,  6'd30, 14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd31, 14'h0404));
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd30, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd30, 14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd14, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd14, 14'h020D));
        foreach (rows[i]) begin
            @(negedge clk);
            moc = rows[i].m; cond_true = rows[i].c; enc_state = rows[i].e;
            #1;
            total++;
            if (state !== rows[i].s || obs !== rows[i].o) begin
                bad++;
                $display("FAIL beq[%0d]: state=%0d out=%h, expected state=%0d out=%h",
                         i, state, obs, rows[i].s, rows[i].o);
            end
        end
    endtask

    task automatic test_timeout;
        row_t rows[$];
        rows.push_back(r(0, 0, 6'd0, 6'd1, 14'h2000));
        rows.push_back(r(0, 0, 6'd0, 6'd2, 14'h04E0));
        for (int k = 0; k < 15; k++) rows.push_back(r(0, 0, 6'd0, 6'd3, 14'h0060));
        rows.push_back(r(0, 0, 6'd0, 6'd3, 14'h0070));
        rows.push_back(r(0, 0, 6'd0, 6'd1, 14'h2000));
        rows.push_back(r(0, 0, 6'd0, 6'd2, 14'h04E0));
        for (int k = 0; k < 15; k++) rows.push_back(r(0, 0, 6'd0, 6'd3, 14'h0060));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd13, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd13, 14'h010A));
        foreach (rows[i]) begin
            @(negedge clk);
            moc = rows[i].m; cond_true = rows[i].c; enc_state = rows[i].e;
            #1;
            total++;
            if (state !== rows[i].s || obs !== rows[i].o) begin
                bad++;
                $display("FAIL timeout[%0d]: state=%0d out=%h, expected state=%0d out=%h",
                         i, state, obs, rows[i].s, rows[i].o);
            end
        end
    endtask

    task automatic test_illegal_str;
        row_t rows[$];
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd7,  6'd4,  14'h0000));
        rows.push_back(r(1, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(1, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd25, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd25, 14'h2004));
        rows.push_back(r(0, 0, 6'd0,  6'd26, 14'h1000));
        rows.push_back(r(0, 0, 6'd0,  6'd27, 14'h0040));
        rows.push_back(r(1, 0, 6'd0,  6'd27, 14'h0040));
        foreach (rows[i]) begin
            @(negedge clk);
            moc = rows[i].m; cond_true = rows[i].c; enc_state = rows[i].e;
            #1;
            total++;
            if (state !== rows[i].s || obs !== rows[i].o) begin
                bad++;
                $display("FAIL illegal_str[%0d]: state=%0d out=%h, expected state=%0d out=%h",
                         i, state, obs, rows[i].s, rows[i].o);
            end
        end
    endtask

    task automatic test_reset_mid;
        row_t rows[$];
        rows.push_back(r(0, 0, 6'd0,  6'd1,  14'h2000));
        rows.push_back(r(0, 0, 6'd0,  6'd2,  14'h04E0));
        rows.push_back(r(1, 0, 6'd0,  6'd3,  14'h1860));
        rows.push_back(r(0, 0, 6'd20, 6'd4,  14'h0000));
        rows.push_back(r(0, 0, 6'd0,  6'd20, 14'h2004));
        rows.push_back(r(0, 0, 6'd0,  6'd21, 14'h0060));
        foreach (rows[i]) begin
            @(negedge clk);
            moc = rows[i].m; cond_true = rows[i].c; enc_state = rows[i].e;
            #1;
            total++;
            if (state !== rows[i].s || obs !== rows[i].o) begin
                bad++;
                $display("FAIL reset_mid[%0d]: state=%0d out=%h, expected state=%0d out=%h",
                         i, state, obs, rows[i].s, rows[i].o);
            end
        end
        #1 reset = 1'b1; moc = 1'b1;
        #1;
        total++;
        if (state !== 6'd0 || obs !== 14'h0000) begin
            bad++;
            $display("FAIL reset_async: state=%0d out=%h, expected state=0 out=0000", state, obs);
        end
        @(negedge clk); #1;
        total++;
        if (state !== 6'd0 || obs !== 14'h0000) begin
            bad++;
            $display("FAIL reset_mid_held: state=%0d out=%h, expected state=0 out=0000", state, obs);
        end
        reset = 1'b0; moc = 1'b0;
        @(negedge clk); #1;
        total++;
        if (state !== 6'd1 || obs !== 14'h2000) begin
            bad++;
            $display("FAIL reset_release: state=%0d out=%h, expected state=1 out=2000", state, obs);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_ldr_wait();
        test_beq();
        test_timeout();
        test_illegal_str();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
